// File: rtl/pc_fetch_sequencer_if.sv
// Bus between the fetch sequencer and its RAM, ALU and control environment.
// The master modport is the sequencer's view; slave is the environment's.
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               stall;
    logic               branch_valid;
    logic [ADDR_W-1:0]  branch_target;
    logic               alu_ready;
    logic [INSTR_W-1:0] instruction_from_RAM;
    logic [ADDR_W-1:0]  ram_addr;
    logic [INSTR_W-1:0] instruction_to_ALU;
    logic               instr_valid;
    logic [ADDR_W-1:0]  PC;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        input  stall, branch_valid, branch_target, alu_ready, instruction_from_RAM,
        output ram_addr, instruction_to_ALU, instr_valid, PC, halted, fetch_count
    );

    modport slave (
        output stall, branch_valid, branch_target, alu_ready, instruction_from_RAM,
        input  ram_addr, instruction_to_ALU, instr_valid, PC, halted, fetch_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer: addresses RAM, waits out the read
// latency, issues to the ALU over valid/ready, handles branch redirect and halt.
module pc_fetch_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_STEP  = 1,
    parameter int                RAM_LAT  = 1,
    parameter int                OP_W     = 6,
    parameter logic [OP_W-1:0]   HALT_OP  = 6'h3F,
    parameter int                CNT_W    = 16
) (
    input logic                  clk,
    input logic                  rst,
    pc_fetch_sequencer_if.master bus
);
    localparam int                LAT_W    = 3;
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RAM_LAT - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1'b1);
    localparam logic [LAT_W-1:0]  LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  pc_r, pc_s;
    logic [LAT_W-1:0]   lat_cnt_r, lat_cnt_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic               valid_r, valid_s;
    logic               halted_r, halted_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;

    logic               branch_s;
    logic               accept_s;
    logic               halt_op_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Halt only blocks redirects; an accept in the branch cycle is still counted.
    assign branch_s  = bus.branch_valid && (state_r != S_HALT);
    assign accept_s  = (state_r == S_ISSUE) && bus.alu_ready;
    assign halt_op_s = (instr_r[INSTR_W-1 -: OP_W] == HALT_OP);
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            lat_cnt_r <= LAT_ZERO;
            instr_r   <= {INSTR_W{1'b0}};
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            lat_cnt_r <= lat_cnt_s;
            instr_r   <= instr_s;
            valid_r   <= valid_s;
            halted_r  <= halted_s;
            cnt_r     <= cnt_s;
        end
    end

    // Next-state logic; a live branch always restarts at FETCH.
    always_comb begin
        state_s = state_r;
        if (branch_s) begin
            state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: state_s = bus.stall ? S_FETCH : S_WAIT;
                S_WAIT: begin
                    if (!bus.stall && (lat_cnt_r == LAT_ZERO)) state_s = S_ISSUE;
                    else                                       state_s = S_WAIT;
                end
                S_ISSUE: begin
                    if (!bus.alu_ready) state_s = S_ISSUE;
                    else if (halt_op_s) state_s = S_HALT;
                    else                state_s = S_FETCH;
                end
                S_HALT:  state_s = S_HALT;
                default: state_s = S_FETCH;
            endcase
        end
    end

    // Datapath next values: PC, latency counter, issue register, status.
    always_comb begin
        pc_s      = pc_r;
        lat_cnt_s = lat_cnt_r;
        instr_s   = instr_r;
        valid_s   = valid_r;
        halted_s  = halted_r;
        cnt_s     = cnt_r;
        if (branch_s) begin
            pc_s    = bus.branch_target;
            valid_s = 1'b0;
            if (accept_s) cnt_s = cnt_inc_s;
            else          cnt_s = cnt_r;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!bus.stall) lat_cnt_s = LAT_LOAD;
                    else            lat_cnt_s = lat_cnt_r;
                end
                S_WAIT: begin
                    if (bus.stall) begin
                        lat_cnt_s = lat_cnt_r;
                    end else if (lat_cnt_r != LAT_ZERO) begin
                        lat_cnt_s = lat_cnt_r - LAT_ONE;
                    end else begin
                        instr_s = bus.instruction_from_RAM;
                        valid_s = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.alu_ready) begin
                        valid_s = 1'b0;
                        cnt_s   = cnt_inc_s;
                        if (halt_op_s) halted_s = 1'b1;
                        else           pc_s     = pc_r + STEP;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                S_HALT:  valid_s = 1'b0;
                default: valid_s = 1'b0;
            endcase
        end
    end

    assign bus.ram_addr           = pc_r;
    assign bus.PC                 = pc_r;
    assign bus.instruction_to_ALU = instr_r;
    assign bus.instr_valid        = valid_r;
    assign bus.halted             = halted_r;
    assign bus.fetch_count        = cnt_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench: instance A (RAM_LAT=1) runs a vector table plus halt sequences;
// instance B (RAM_LAT=3, RESET_PC=0xFFFF, CNT_W=2) covers hold, wrap and saturation.
module tb_pc_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    pc_fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(32), .CNT_W(16)) ifa ();
    pc_fetch_sequencer_if #(.ADDR_W(16), .INSTR_W(32), .CNT_W(2))  ifb ();

    pc_fetch_sequencer #(.RAM_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    pc_fetch_sequencer #(.RAM_LAT(3), .RESET_PC(16'hFFFF), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] pipe_b1, pipe_b2;

    // RAM models: one-stage read for A, three-stage read for B.
    always @(posedge clk) begin
        ifa.instruction_from_RAM <= mem_a[ifa.ram_addr[7:0]];
        pipe_b1                  <= mem_b[ifb.ram_addr[7:0]];
        pipe_b2                  <= pipe_b1;
        ifb.instruction_from_RAM <= pipe_b2;
    end

    typedef struct {
        logic        rst, stall, br;
        logic [15:0] tgt;
        logic        rdy;
        logic        v;
        logic [31:0] ins;
        logic [15:0] pc;
        logic        h;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic b, input logic [15:0] t,
                       input logic rd, input logic v, input logic [31:0] ins,
                       input logic [15:0] pc, input logic h, input logic [15:0] c);
        vec_t e;
        e.rst = r; e.stall = s; e.br = b; e.tgt = t; e.rdy = rd;
        e.v = v; e.ins = ins; e.pc = pc; e.h = h; e.cnt = c;
        tbl.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic v, input logic [31:0] ins,
                           input logic [15:0] pc, input logic h, input logic [15:0] c);
        n_vec++;
        if (ifa.instr_valid !== v || ifa.instruction_to_ALU !== ins || ifa.PC !== pc ||
            ifa.ram_addr !== pc || ifa.halted !== h || ifa.fetch_count !== c) begin
            n_err++;
            $display("FAIL %s: got v=%b instr=%h pc=%h addr=%h halted=%b cnt=%0d, required v=%b instr=%h pc=%h halted=%b cnt=%0d",
                     name, ifa.instr_valid, ifa.instruction_to_ALU, ifa.PC, ifa.ram_addr,
                     ifa.halted, ifa.fetch_count, v, ins, pc, h, c);
        end
    endtask

    task automatic check_b(input string name, input logic v, input logic [31:0] ins,
                           input logic [15:0] pc, input logic [1:0] c);
        n_vec++;
        if (ifb.instr_valid !== v || ifb.instruction_to_ALU !== ins || ifb.PC !== pc ||
            ifb.ram_addr !== pc || ifb.halted !== 1'b0 || ifb.fetch_count !== c) begin
            n_err++;
            $display("FAIL %s: got v=%b instr=%h pc=%h addr=%h halted=%b cnt=%0d, required v=%b instr=%h pc=%h halted=0 cnt=%0d",
                     name, ifb.instr_valid, ifb.instruction_to_ALU, ifb.PC, ifb.ram_addr,
                     ifb.halted, ifb.fetch_count, v, ins, pc, c);
        end
    endtask

    task automatic wait_valid_a(input string name);
        int n = 0;
        while (ifa.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_vec++;
        if (ifa.instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: instr_valid=%b after 20 cycles, required 1", name, ifa.instr_valid);
        end
    endtask

    task automatic wait_valid_b(input string name);
        int n = 0;
        while (ifb.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_vec++;
        if (ifb.instr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: instr_valid=%b after 20 cycles, required 1", name, ifb.instr_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0100_0000 + i;
            mem_b[i] = 32'h0200_0000 + i;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.stall = 1'b0; ifa.branch_valid = 1'b0; ifa.branch_target = 16'h0000; ifa.alu_ready = 1'b0;
        ifb.stall = 1'b0; ifb.branch_valid = 1'b0; ifb.branch_target = 16'h0000; ifb.alu_ready = 1'b0;

        //   rst   stall br    tgt       rdy  | v     instr          pc        h     cnt
        add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0000, 16'h0001, 1'b0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0000, 16'h0001, 1'b0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0001, 16'h0001, 1'b0, 16'd1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0001, 16'h0002, 1'b0, 16'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0001, 16'h0002, 1'b0, 16'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0002, 16'h0002, 1'b0, 16'd2);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0002, 16'h0003, 1'b0, 16'd3);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0002, 16'h0003, 1'b0, 16'd3);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0003, 16'h0003, 1'b0, 16'd3);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0003, 16'h0004, 1'b0, 16'd4);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0003, 16'h0004, 1'b0, 16'd4);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0004, 16'h0004, 1'b0, 16'd4);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0004, 16'h0005, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0004, 16'h0005, 1'b0, 16'd5);
        // branch in WAIT discards PC 5; branch with stall is still taken
        add(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 32'h0100_0004, 16'h0040, 1'b0, 16'd5);
        add(1'b0, 1'b1, 1'b1, 16'h0050, 1'b1, 1'b0, 32'h0100_0004, 16'h0050, 1'b0, 16'd5);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0004, 16'h0050, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0004, 16'h0050, 1'b0, 16'd5);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0004, 16'h0050, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0100_0050, 16'h0050, 1'b0, 16'd5);
        // branch in ISSUE without accept drops the instruction uncounted
        add(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 32'h0100_0050, 16'h0010, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0100_0050, 16'h0010, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0100_0010, 16'h0010, 1'b0, 16'd5);
        add(1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 1'b0, 32'h0100_0010, 16'h0020, 1'b0, 16'd6);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0010, 16'h0020, 1'b0, 16'd6);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 32'h0100_0020, 16'h0020, 1'b0, 16'd6);
        add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0020, 16'h0021, 1'b0, 16'd7);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0020, 16'h0021, 1'b0, 16'd7);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0100_0021, 16'h0021, 1'b0, 16'd7);
        // reset while an instruction is being offered
        add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0100_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h0100_0000, 16'h0000, 1'b0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0100_0000, 16'h0001, 1'b0, 16'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_a             = tbl[i].rst;
            ifa.stall         = tbl[i].stall;
            ifa.branch_valid  = tbl[i].br;
            ifa.branch_target = tbl[i].tgt;
            ifa.alu_ready     = tbl[i].rdy;
            tick();
            check_a($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].h, tbl[i].cnt);
        end

        // Halt opcode at address 2: fetch stops, branch ignored, only rst recovers.
        mem_a[2] = 32'hFC00_0002;
        rst_a = 1'b1; ifa.stall = 1'b0; ifa.branch_valid = 1'b0; ifa.alu_ready = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid_a($sformatf("halt_pre_valid%0d", k));
            tick();
            check_a($sformatf("halt_pre_acc%0d", k), 1'b0, 32'h0100_0000 + k, 16'(k + 1), 1'b0, 16'(k + 1));
        end
        wait_valid_a("halt_valid");
        tick();
        check_a("halt_enter", 1'b0, 32'hFC00_0002, 16'h0002, 1'b1, 16'd3);
        ifa.branch_valid = 1'b1; ifa.branch_target = 16'h0030;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_a($sformatf("halt_hold%0d", k), 1'b0, 32'hFC00_0002, 16'h0002, 1'b1, 16'd3);
        end
        ifa.branch_valid = 1'b0; rst_a = 1'b1;
        tick();
        check_a("halt_rst", 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 16'd0);

        // Branch in the same cycle as the halt-op accept wins: counted, no halt.
        rst_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid_a($sformatf("bh_pre_valid%0d", k));
            tick();
        end
        wait_valid_a("bh_valid");
        ifa.branch_valid = 1'b1; ifa.branch_target = 16'h0030;
        tick();
        check_a("branch_over_halt", 1'b0, 32'hFC00_0002, 16'h0030, 1'b0, 16'd3);
        ifa.branch_valid = 1'b0;
        wait_valid_a("bh_post_valid");
        check_a("bh_post_instr", 1'b1, 32'h0100_0030, 16'h0030, 1'b0, 16'd3);

        // Instance B: latency 3, ALU back-pressure, PC wrap and counter saturation.
        rst_b = 1'b1;
        tick();
        check_b("b_reset", 1'b0, 32'h0000_0000, 16'hFFFF, 2'd0);
        rst_b = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_b($sformatf("b_lat%0d", k), 1'b0, 32'h0000_0000, 16'hFFFF, 2'd0);
        end
        tick();
        check_b("b_first_valid", 1'b1, 32'h0200_00FF, 16'hFFFF, 2'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_b($sformatf("b_hold%0d", k), 1'b1, 32'h0200_00FF, 16'hFFFF, 2'd0);
        end
        ifb.alu_ready = 1'b1;
        tick();
        check_b("b_wrap", 1'b0, 32'h0200_00FF, 16'h0000, 2'd1);
        for (int k = 2; k <= 5; k++) begin
            wait_valid_b($sformatf("b_valid%0d", k));
            check_b($sformatf("b_instr%0d", k), 1'b1, 32'h0200_0000 + (k - 2), 16'(k - 2),
                    (k - 1 > 3) ? 2'd3 : 2'(k - 1));
            tick();
            check_b($sformatf("b_acc%0d", k), 1'b0, 32'h0200_0000 + (k - 2), 16'(k - 1),
                    (k > 3) ? 2'd3 : 2'(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
